// File: rtl/rwb_pkg.sv
// Shared types and default sizing for the result writeback unit.
package rwb_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned ELEM_W     = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } rwb_state_e;

endpackage

// File: rtl/result_writeback_unit_if.sv
// SRAM-style write port: one word per wr_en && ready handshake.
interface result_writeback_unit_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
);

  logic              mem_wr_en;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  modport master (
    output mem_wr_en,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/requant_sat.sv
// Unsigned requantization: right shift with round-half-up, saturate to WIDTH bits.
module requant_sat #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH-1:0]         elem,
  input  logic [$clog2(2*WIDTH)-1:0] shift,
  output logic [WIDTH-1:0]           q
);

  localparam int unsigned RW = 2 * WIDTH + 1;

  logic [RW-1:0] ext;
  logic [RW-1:0] half;
  logic [RW-1:0] r;

  always_comb begin
    ext  = {1'b0, elem};
    half = '0;
    r    = ext;
    if (shift != '0) begin
      // Extra top bit keeps the rounding carry out of 0xFFFF-style inputs.
      half = RW'(1) << (shift - 1'b1);
      r    = (ext + half) >> shift;
    end
    q = (|r[RW-1:WIDTH]) ? '1 : r[WIDTH-1:0];
  end

endmodule

// File: rtl/result_writeback_unit.sv
// Requantizes a DEPTH-element MAC result vector and writes it word by word to memory,
// with one pending-vector buffer and a sticky overflow flag for dropped vectors.
module result_writeback_unit
  import rwb_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic [$clog2(2*WIDTH)-1:0]   cfg_shift,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic                         in_valid,
  input  logic [2*WIDTH*DEPTH-1:0]     in_data,
  result_writeback_unit_if.master      mem,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int unsigned EW   = 2 * WIDTH;
  localparam int unsigned ShW  = $clog2(EW);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned VecW = EW * DEPTH;

  rwb_state_e        state_q;
  logic [VecW-1:0]   work_q;
  logic [VecW-1:0]   pend_q;
  logic              pend_valid_q;
  logic [ShW-1:0]    shift_q;
  logic [IdxW-1:0]   elem_idx_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              overflow_q;

  logic [EW-1:0]     elem;
  logic [WIDTH-1:0]  wdata;
  logic              last_elem;

  assign elem      = work_q[elem_idx_q*EW +: EW];
  assign last_elem = (elem_idx_q == IdxW'(DEPTH - 1));

  requant_sat #(
    .WIDTH (WIDTH)
  ) u_requant (
    .elem  (elem),
    .shift (shift_q),
    .q     (wdata)
  );

  assign mem.mem_wr_en = (state_q == StWrite);
  assign mem.mem_addr  = cfg_base_addr + wr_ptr_q;
  assign mem.mem_wdata = wdata;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign overflow      = overflow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      work_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shift_q      <= '0;
      elem_idx_q   <= '0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (pend_valid_q) begin
            // Pending vector moves to work; a same-cycle arrival refills pend.
            work_q       <= pend_q;
            shift_q      <= cfg_shift;
            state_q      <= StWrite;
            pend_valid_q <= in_valid;
            if (in_valid) pend_q <= in_data;
          end else if (in_valid) begin
            work_q  <= in_data;
            shift_q <= cfg_shift;
            state_q <= StWrite;
          end else begin
            state_q <= StIdle;
          end
        end
        StWrite: begin
          if (mem.mem_ready) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_elem) begin
              elem_idx_q <= '0;
              state_q    <= StDone;
            end else begin
              elem_idx_q <= elem_idx_q + 1'b1;
            end
          end
          if (in_valid) begin
            if (!pend_valid_q) begin
              pend_q       <= in_data;
              pend_valid_q <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (clear) begin
        wr_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end
    end
  end

endmodule
